stream_bank_loader: RTL and testbench

Parametrised stream-to-double-buffer loader for the conv datapath. It packs LANES narrow stream words into one wide bank word and writes it to the write bank of a `double_buffer`. It issues `switch_banks` only when the reader has released the read bank, and applies real back-pressure instead of a hard-wired ready. It replaces the per-stream ad-hoc FIFO-to-buffer logic, is runtime-configurable in fill depth, and supports early stream termination with zero padding.

---
 rtl/stream_bank_loader_pkg.sv | 20 ++
 rtl/stream_bank_loader_if.sv | 38 +++
 rtl/stream_bank_loader_lane_packer.sv | 53 +++++
 rtl/stream_bank_loader.sv | 108 ++++++++++
 tb/tb_stream_bank_loader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_bank_loader_pkg.sv
// Shared types and defaults for the stream-to-double-buffer loader.
// Latency: none; declarations only. Backpressure: not applicable.
package stream_bank_loader_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LANES      = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FLUSH,
    WAIT_SWAP
  } loader_state_t;

  // A fill must write at least one word and cannot exceed the bank depth.
  function automatic logic words_legal(input int words, input int depth);
    return (words != 0) && (words <= depth);
  endfunction

endpackage

// File: rtl/stream_bank_loader_if.sv
// Config, stream, bank-write and bank-swap signals between loader and its neighbours.
// Latency: none; wires only. Backpressure: carried by cfg_rdy, s_rdy and the swap handshake.
interface stream_bank_loader_if
  import stream_bank_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LANES           = DEF_LANES,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int CONFIG_WIDTH    = BANK_ADDR_WIDTH + 1
);

  logic [CONFIG_WIDTH-1:0]     cfg_words;
  logic                        cfg_vld;
  logic                        cfg_rdy;
  logic                        cfg_err;
  logic [DATA_WIDTH-1:0]       s_dat;
  logic                        s_vld;
  logic                        s_last;
  logic                        s_rdy;
  logic                        wen;
  logic [BANK_ADDR_WIDTH-1:0]  wadr;
  logic [DATA_WIDTH*LANES-1:0] wdata;
  logic                        switch_banks;
  logic                        rd_bank_done;
  logic                        rd_bank_vld;
  logic [CONFIG_WIDTH-1:0]     rd_words;

  modport master (
    output cfg_words, cfg_vld, s_dat, s_vld, s_last, rd_bank_done,
    input  cfg_rdy, cfg_err, s_rdy, wen, wadr, wdata, switch_banks, rd_bank_vld, rd_words
  );

  modport slave (
    input  cfg_words, cfg_vld, s_dat, s_vld, s_last, rd_bank_done,
    output cfg_rdy, cfg_err, s_rdy, wen, wadr, wdata, switch_banks, rd_bank_vld, rd_words
  );

endinterface

// File: rtl/stream_bank_loader_lane_packer.sv
// Packs LANES stream words into one bank word, zero-padding lanes after an early last.
// Latency: word_vld/word_dat registered, 1 cycle after the completing handshake. Backpressure: none; en is the handshake.
module lane_packer
  import stream_bank_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [DATA_WIDTH-1:0]       dat,
  input  logic                        last,
  output logic                        word_done,
  output logic                        word_vld,
  output logic [DATA_WIDTH*LANES-1:0] word_dat
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  logic [LW-1:0]                         lane_cnt;
  logic [LANES-1:0][DATA_WIDTH-1:0]      lanes_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]      packed_w;

  // Lanes above lane_cnt are always zero here, so an early last pads for free.
  always_comb begin
    packed_w           = lanes_q;
    packed_w[lane_cnt] = dat;
  end

  assign word_done = en && ((lane_cnt == LAST_LANE) || last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt <= '0;
      lanes_q  <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= word_done;
      if (word_done) begin
        word_dat <= packed_w;
        lanes_q  <= '0;
        lane_cnt <= '0;
      end else if (en) begin
        lanes_q  <= packed_w;
        lane_cnt <= lane_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_bank_loader.sv
// Loads packed stream words into the write bank of a double buffer and requests bank swaps.
// Latency: wen 1 cycle after the completing handshake, swap 2 cycles. Backpressure: s_rdy low outside FILL, WAIT_SWAP holds until the reader releases.
module stream_bank_loader
  import stream_bank_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LANES           = DEF_LANES,
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int CONFIG_WIDTH    = BANK_ADDR_WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst,
  stream_bank_loader_if.slave bus
);

  loader_state_t state, state_nxt;

  logic                        cfg_rdy, s_rdy, swap;
  logic                        cfg_hs, cfg_ok, s_hs;
  logic                        word_done, word_vld, fill_end;
  logic [DATA_WIDTH*LANES-1:0] word_dat;
  logic [CONFIG_WIDTH-1:0]     cfg_q, word_cnt, pending_words, rd_words_q;
  logic [BANK_ADDR_WIDTH-1:0]  wadr_q;
  logic                        cfg_err_q, rd_bank_vld_q;

  lane_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .en        (s_hs),
    .dat       (bus.s_dat),
    .last      (bus.s_last),
    .word_done (word_done),
    .word_vld  (word_vld),
    .word_dat  (word_dat)
  );

  assign cfg_hs   = bus.cfg_vld && cfg_rdy;
  assign cfg_ok   = words_legal(32'(bus.cfg_words), 2 ** BANK_ADDR_WIDTH);
  assign s_hs     = bus.s_vld && s_rdy;
  assign fill_end = word_done && (bus.s_last || (word_cnt == cfg_q - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (cfg_hs && cfg_ok) state_nxt = FILL;
      FILL:      if (fill_end)         state_nxt = FLUSH;
      FLUSH:                           state_nxt = WAIT_SWAP;
      WAIT_SWAP: if (swap)             state_nxt = FILL;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_rdy = (state == IDLE);
    s_rdy   = (state == FILL);
    swap    = (state == WAIT_SWAP) && (!rd_bank_vld_q || bus.rd_bank_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q         <= '0;
      cfg_err_q     <= 1'b0;
      word_cnt      <= '0;
      pending_words <= '0;
      wadr_q        <= '0;
      rd_bank_vld_q <= 1'b0;
      rd_words_q    <= '0;
    end else begin
      cfg_err_q <= cfg_hs && !cfg_ok;
      if (cfg_hs && cfg_ok) begin
        cfg_q    <= bus.cfg_words;
        word_cnt <= '0;
        wadr_q   <= '0;
      end
      if (word_done) word_cnt <= word_cnt + 1'b1;
      if (word_vld)  wadr_q   <= wadr_q + 1'b1;
      if (state == FLUSH) pending_words <= word_cnt;
      // A release coincident with the swap refers to the old bank; the new one is live.
      if (swap) begin
        wadr_q        <= '0;
        word_cnt      <= '0;
        rd_bank_vld_q <= 1'b1;
        rd_words_q    <= pending_words;
      end else if (bus.rd_bank_done) begin
        rd_bank_vld_q <= 1'b0;
      end
    end
  end

  assign bus.cfg_rdy      = cfg_rdy;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.s_rdy        = s_rdy;
  assign bus.wen          = word_vld;
  assign bus.wadr         = wadr_q;
  assign bus.wdata        = word_dat;
  assign bus.switch_banks = swap;
  assign bus.rd_bank_vld  = rd_bank_vld_q;
  assign bus.rd_words     = rd_words_q;

endmodule

// File: tb/tb_stream_bank_loader.sv
// Bench for stream_bank_loader: fill vectors, swap timing, back-pressure, bad config, reset, bursty input.
module tb_stream_bank_loader;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int BAW = 3;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_bank_loader_if #(.DATA_WIDTH(DW), .LANES(LN), .BANK_ADDR_WIDTH(BAW), .CONFIG_WIDTH(CW)) bus ();

  stream_bank_loader #(.DATA_WIDTH(DW), .LANES(LN), .BANK_ADDR_WIDTH(BAW), .CONFIG_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [BAW-1:0]   adr;
    logic [DW*LN-1:0] dat;
  } wr_t;

  typedef struct {
    int cfg;
    int nwords;
    bit last;
    int exp_rd;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];

  int errors = 0;
  int checks = 0;
  int sw_cnt = 0;

  logic done_man  = 1'b0;
  logic done_auto = 1'b0;
  bit   auto_rd   = 1'b0;
  assign bus.rd_bank_done = done_man | done_auto;

  int               m_lane, m_addr, m_cfg;
  logic [DW*LN-1:0] m_word;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every bank write must match the next expected word.
  always @(negedge clk) begin
    if (!rst && bus.wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wen: actual wadr=%0h wdata=%0h required no write", bus.wadr, bus.wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wadr", 64'(bus.wadr), 64'(e.adr));
        chk("wdata", 64'(bus.wdata), 64'(e.dat));
      end
    end
    if (!rst && bus.switch_banks) sw_cnt++;
  end

  initial begin
    forever begin
      step();
      #1;
      done_auto = auto_rd && bus.rd_bank_vld && !done_auto && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic model_reset(input int cfg);
    m_cfg  = cfg;
    m_lane = 0;
    m_addr = 0;
    m_word = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input int gap);
    bit  hs;
    int  t;
    wr_t w;
    bus.s_vld = 1'b0;
    repeat (gap) step();
    bus.s_dat  = d;
    bus.s_last = last;
    bus.s_vld  = 1'b1;
    hs = 1'b0;
    t  = 0;
    while (!hs && t < 300) begin
      @(negedge clk);
      hs = bus.s_rdy;
      step();
      t++;
    end
    bus.s_vld  = 1'b0;
    bus.s_last = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: actual s_rdy=0 for word %0h required s_rdy=1", d);
      return;
    end
    m_word[m_lane*DW +: DW] = d;
    if (m_lane == LN - 1 || last) begin
      w.adr = BAW'(m_addr);
      w.dat = m_word;
      exp_q.push_back(w);
      m_addr++;
      if (m_addr == m_cfg || last) m_addr = 0;
      m_word = '0;
      m_lane = 0;
    end else begin
      m_lane++;
    end
  endtask

  task automatic do_reset(input bit check_vals);
    rst           = 1'b1;
    bus.cfg_vld   = 1'b0;
    bus.cfg_words = '0;
    bus.s_vld     = 1'b0;
    bus.s_last    = 1'b0;
    bus.s_dat     = '0;
    done_man      = 1'b0;
    auto_rd       = 1'b0;
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    if (check_vals) begin
      chk("rst_cfg_rdy", 64'(bus.cfg_rdy), 64'(1));
      chk("rst_cfg_err", 64'(bus.cfg_err), 64'(0));
      chk("rst_s_rdy", 64'(bus.s_rdy), 64'(0));
      chk("rst_wen", 64'(bus.wen), 64'(0));
      chk("rst_wadr", 64'(bus.wadr), 64'(0));
      chk("rst_wdata", 64'(bus.wdata), 64'(0));
      chk("rst_switch", 64'(bus.switch_banks), 64'(0));
      chk("rst_rd_bank_vld", 64'(bus.rd_bank_vld), 64'(0));
      chk("rst_rd_words", 64'(bus.rd_words), 64'(0));
    end
    step();
  endtask

  task automatic configure(input int v, input bit exp_err);
    bus.cfg_words = CW'(v);
    bus.cfg_vld   = 1'b1;
    step();
    bus.cfg_vld = 1'b0;
    @(negedge clk);
    chk("cfg_err", 64'(bus.cfg_err), 64'(exp_err));
    chk("cfg_rdy", 64'(bus.cfg_rdy), 64'(exp_err));
    chk("s_rdy_after_cfg", 64'(bus.s_rdy), 64'(!exp_err));
    step();
  endtask

  task automatic wait_swaps(input int target, input int budget, input string name);
    int t;
    t = 0;
    while (sw_cnt < target && t < budget) begin
      step();
      t++;
    end
    chk(name, 64'(sw_cnt), 64'(target));
  endtask

  initial begin
    int  base;
    int  start;
    int  gap;
    bit  held;

    vecs[0] = '{cfg: 2, nwords: 8,  last: 1'b0, exp_rd: 2};
    vecs[1] = '{cfg: 4, nwords: 6,  last: 1'b1, exp_rd: 2};
    vecs[2] = '{cfg: 8, nwords: 32, last: 1'b0, exp_rd: 8};
    vecs[3] = '{cfg: 1, nwords: 3,  last: 1'b1, exp_rd: 1};
    vecs[4] = '{cfg: 3, nwords: 8,  last: 1'b1, exp_rd: 2};

    do_reset(1'b1);

    for (int v = 0; v < 5; v++) begin
      if (v > 0) do_reset(1'b0);
      base = v * 64;
      configure(vecs[v].cfg, 1'b0);
      model_reset(vecs[v].cfg);
      start = sw_cnt;
      for (int i = 0; i < vecs[v].nwords; i++)
        send(DW'(base + i + 1), vecs[v].last && (i == vecs[v].nwords - 1), 0);
      wait_swaps(start + 1, 20, "vec_swap");
      chk("vec_rd_bank_vld", 64'(bus.rd_bank_vld), 64'(1));
      chk("vec_rd_words", 64'(bus.rd_words), 64'(vecs[v].exp_rd));
      chk("vec_wadr_cleared", 64'(bus.wadr), 64'(0));
      chk("vec_all_written", 64'(exp_q.size()), 64'(0));
    end

    // Minimum swap latency, then a swap held off by an unreleased read bank.
    do_reset(1'b0);
    configure(2, 1'b0);
    model_reset(2);
    for (int i = 0; i < 8; i++) send(DW'(i + 1), 1'b0, 0);
    @(negedge clk);
    chk("flush_wen", 64'(bus.wen), 64'(1));
    chk("flush_wadr", 64'(bus.wadr), 64'(1));
    chk("flush_s_rdy", 64'(bus.s_rdy), 64'(0));
    step();
    @(negedge clk);
    chk("swap_latency", 64'(bus.switch_banks), 64'(1));
    step();
    @(negedge clk);
    chk("s_rdy_after_swap", 64'(bus.s_rdy), 64'(1));
    chk("rd_words_first", 64'(bus.rd_words), 64'(2));
    chk("rd_bank_vld_first", 64'(bus.rd_bank_vld), 64'(1));
    step();
    for (int i = 0; i < 8; i++) send(DW'(i + 9), 1'b0, 0);
    held = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.s_rdy || bus.switch_banks) held = 1'b0;
      step();
    end
    chk("backpressure_hold", 64'(held), 64'(1));
    done_man = 1'b1;
    @(negedge clk);
    chk("swap_on_done", 64'(bus.switch_banks), 64'(1));
    step();
    done_man = 1'b0;
    chk("rd_bank_vld_kept", 64'(bus.rd_bank_vld), 64'(1));
    chk("rd_words_second", 64'(bus.rd_words), 64'(2));
    @(negedge clk);
    chk("s_rdy_after_done", 64'(bus.s_rdy), 64'(1));
    chk("bp_all_written", 64'(exp_q.size()), 64'(0));
    step();

    // Illegal configs are dropped without leaving IDLE.
    do_reset(1'b0);
    configure(0, 1'b1);
    @(negedge clk);
    chk("cfg_err_one_cycle", 64'(bus.cfg_err), 64'(0));
    chk("s_rdy_idle", 64'(bus.s_rdy), 64'(0));
    step();
    configure(9, 1'b1);
    configure(8, 1'b0);

    // Reset in the middle of a word discards the partial lanes.
    do_reset(1'b0);
    configure(2, 1'b0);
    model_reset(2);
    for (int i = 0; i < 3; i++) send(DW'(16'h0a1 + i), 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wen", 64'(bus.wen), 64'(0));
    chk("midrst_s_rdy", 64'(bus.s_rdy), 64'(0));
    chk("midrst_cfg_rdy", 64'(bus.cfg_rdy), 64'(1));
    chk("midrst_wdata", 64'(bus.wdata), 64'(0));
    chk("midrst_switch", 64'(bus.switch_banks), 64'(0));
    step();
    rst = 1'b0;
    step();
    configure(2, 1'b0);
    model_reset(2);
    start = sw_cnt;
    for (int i = 0; i < 8; i++) send(DW'(16'h201 + i), 1'b0, 0);
    wait_swaps(start + 1, 20, "midrst_swap");

    // Sparse valid with a reader that releases banks at random.
    do_reset(1'b0);
    configure(4, 1'b0);
    model_reset(4);
    auto_rd = 1'b1;
    start = sw_cnt;
    for (int i = 0; i < 64; i++) begin
      gap = 0;
      while (gap < 20 && $urandom_range(0, 99) >= 30) gap++;
      send(DW'(16'h300 + i), 1'b0, gap);
    end
    wait_swaps(start + 4, 300, "bursty_swaps");
    chk("bursty_all_written", 64'(exp_q.size()), 64'(0));
    auto_rd = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1);
  end

endmodule
